// File: rtl/regfile_wr_arb_pkg.sv
// Shared widths, constants and the LU result entry type for the regfile write-port arbiter.
package regfile_wr_arb_pkg;

  localparam int unsigned RegAddrW     = 5;
  localparam int unsigned RegW         = 32;
  localparam int unsigned RegNum       = 32;
  localparam logic [RegW-1:0] ZeroWord = '0;
  localparam logic WriteEnable         = 1'b1;
  localparam int unsigned ArbFifoDepth = 2;

  typedef struct packed {
    logic [RegAddrW-1:0] waddr;
    logic [RegW-1:0]     wdata;
  } lu_entry_t;

  // Busy register that is not being cleared by a drain this very cycle; the regfile
  // forwards same-cycle write data, so a draining register no longer blocks ID.
  function automatic logic busy_hit(input logic [RegNum-1:0]   busy,
                                    input logic                drain,
                                    input logic [RegAddrW-1:0] head_addr,
                                    input logic [RegAddrW-1:0] addr);
    return busy[addr] && !(drain && (head_addr == addr));
  endfunction

endpackage

// File: rtl/regfile_wr_arb_fifo.sv
// Synchronous FIFO holding accepted LU results until the write port is free.
module regfile_wr_arb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates the regfile write port between pipeline writeback and buffered LU results,
// and keeps the busy scoreboard that stalls ID on registers still owed by the LU.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = ArbFifoDepth,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_we,
  input  logic [RegAddrW-1:0] wb_waddr,
  input  logic [RegW-1:0]     wb_wdata,
  input  logic                lu_issue,
  input  logic [RegAddrW-1:0] lu_issue_addr,
  input  logic                lu_req,
  input  logic [RegAddrW-1:0] lu_waddr,
  input  logic [RegW-1:0]     lu_wdata,
  output logic                lu_ack,
  input  logic                id_re1,
  input  logic [RegAddrW-1:0] id_raddr1,
  input  logic                id_re2,
  input  logic [RegAddrW-1:0] id_raddr2,
  input  logic                id_we,
  input  logic [RegAddrW-1:0] id_waddr,
  output logic                stall_req,
  output logic                starve_req,
  output logic                we,
  output logic [RegAddrW-1:0] waddr,
  output logic [RegW-1:0]     wdata
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  lu_entry_t         head;
  lu_entry_t         push_entry;
  logic              fifo_full, fifo_empty;
  logic              push, drain;
  logic [RegNum-1:0] busy_q, busy_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              starve_q;

  assign lu_ack     = !fifo_full;
  // Writes to r0 are architecturally discarded, so they are acked and dropped.
  assign push       = lu_req && lu_ack && (lu_waddr != '0);
  assign push_entry = '{waddr: lu_waddr, wdata: lu_wdata};
  assign drain      = !wb_we && !fifo_empty;

  regfile_wr_arb_fifo #(
    .Depth (DEPTH),
    .Width ($bits(lu_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (drain),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    we    = wb_we;
    waddr = wb_waddr;
    wdata = wb_wdata;
    if (!wb_we) begin
      if (!fifo_empty) begin
        we    = WriteEnable;
        waddr = head.waddr;
        wdata = head.wdata;
      end else begin
        we    = 1'b0;
        waddr = '0;
        wdata = ZeroWord;
      end
    end
  end

  // Set is applied after clear so a same-address issue wins over a drain.
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d[head.waddr] = 1'b0;
    if (lu_issue && (lu_issue_addr != '0)) busy_d[lu_issue_addr] = 1'b1;
  end

  assign stall_req = (id_re1 && busy_hit(busy_q, drain, head.waddr, id_raddr1)) ||
                     (id_re2 && busy_hit(busy_q, drain, head.waddr, id_raddr2)) ||
                     (id_we  && busy_hit(busy_q, drain, head.waddr, id_waddr));

  // A non-empty FIFO without a drain implies WB held the port this cycle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || drain) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMaxC) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= (starve_cnt_d == StarveMaxC);
    end
  end

  assign starve_req = starve_q;

endmodule
